// File: rtl/ifra_arb.sv
// ifra_arb: N-to-1 round-robin arbiter sharing one ifra slave port.
// One arbitration cycle per grant; a grant ends on release or after MAX_BEATS beats.
module ifra_arb #(
    parameter int  N_MST     = 4,
    parameter int  DW        = 8,
    parameter int  MAX_BEATS = 16,
    localparam int IDW       = (N_MST > 1) ? $clog2(N_MST) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_MST-1:0]    m_req,
    input  logic [N_MST*DW-1:0] m_dout,
    output logic [N_MST-1:0]    m_ack,
    output logic                s_req,
    output logic [DW-1:0]       s_dout,
    input  logic                s_ack,
    output logic                gnt_valid,
    output logic [IDW-1:0]      gnt_id
);

    localparam int BW = $clog2(MAX_BEATS + 1);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IDW-1:0] r_gnt_id;
    logic [IDW-1:0] r_last;
    logic [IDW-1:0] w_gnt_nxt;
    logic [IDW-1:0] w_last_nxt;
    logic [IDW-1:0] w_win;
    logic [BW-1:0]  r_cnt;
    logic [BW-1:0]  w_cnt_nxt;
    logic [BW-1:0]  w_cnt_inc;
    logic           w_found;
    logic           w_sel_req;
    logic           w_hs;

    function automatic logic [IDW-1:0] wrap_idx(
        input logic [IDW-1:0] base,
        input int             k
    );
        int s;
        s = int'(base) + k;
        if (s >= N_MST) s = s - N_MST;
        return IDW'(s);
    endfunction

    // Search starts just after the previous grantee so it ranks last.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= N_MST; k++) begin
            if (!w_found && m_req[wrap_idx(r_last, k)]) begin
                w_found = 1'b1;
                w_win   = wrap_idx(r_last, k);
            end
        end
    end

    assign w_sel_req = m_req[r_gnt_id];
    assign w_hs      = (r_state == S_BUSY) & w_sel_req & s_ack;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign s_dout    = m_dout[r_gnt_id*DW +: DW];
    assign gnt_valid = (r_state == S_BUSY);
    assign gnt_id    = r_gnt_id;

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt_id;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        s_req       = 1'b0;
        m_ack       = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_BUSY;
                    w_gnt_nxt   = w_win;
                    w_last_nxt  = w_win;
                    w_cnt_nxt   = '0;
                end
            end
            S_BUSY: begin
                s_req           = w_sel_req;
                m_ack[r_gnt_id] = w_hs;
                if (w_hs) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == BW'(MAX_BEATS)) w_state_nxt = S_IDLE;
                end else if (!w_sel_req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_gnt_id <= '0;
            r_last   <= IDW'(N_MST - 1);
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt_id <= w_gnt_nxt;
            r_last   <= w_last_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

endmodule
